// File: rtl/arr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : arr_pkg                                                     |
// | Shared state encoding and default sizing for the array feed path.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package arr_pkg;

   localparam int c_ROWS     = 16;
   localparam int c_WORD_LEN = 8;
   localparam int c_ADDR_W   = 15;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EMIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } feed_state_t;

endpackage
`default_nettype wire

// File: rtl/row_feeder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface : row_feeder_if                                             |
// | Run control, input-memory read port and skewed array row bus.         |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
interface row_feeder_if
   import arr_pkg::*;
#(
   parameter int ROWS     = c_ROWS,
   parameter int WORD_LEN = c_WORD_LEN,
   parameter int ADDR_W   = c_ADDR_W
);
   logic                     start;
   logic [ADDR_W-1:0]        base_addr;
   logic [7:0]               num_vecs;
   logic                     mem_cen;
   logic                     mem_wen;
   logic [ADDR_W-1:0]        mem_a;
   logic [WORD_LEN-1:0]      mem_q;
   logic                     arr_rdy;
   logic [ROWS*WORD_LEN-1:0] row_dat;
   logic [ROWS-1:0]          row_vld;
   logic                     busy;
   logic                     done;

   // Feeder side: drives memory requests and the row bus
   modport master (
      input  start, base_addr, num_vecs, mem_q, arr_rdy,
      output mem_cen, mem_wen, mem_a, row_dat, row_vld, busy, done
   );

   // Environment side: memory, array and run controller
   modport slave (
      output start, base_addr, num_vecs, mem_q, arr_rdy,
      input  mem_cen, mem_wen, mem_a, row_dat, row_vld, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/row_skew.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : row_skew                                                    |
// | Triangular delay line: row r of a pushed vector emerges r+1 cycles    |
// | later. Non-push cycles inject zero-data bubbles.                      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module row_skew #(
   parameter int ROWS     = 16,
   parameter int WORD_LEN = 8
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic [ROWS*WORD_LEN-1:0] vec,
   input  wire logic                     push,
   output logic      [ROWS*WORD_LEN-1:0] row_dat,
   output logic      [ROWS-1:0]          row_vld
);

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [WORD_LEN-1:0] r_d [0:r];
      logic [r:0]          r_v;

      // Row r shift chain of depth r+1; shifts every cycle
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i <= r; i++) r_d[i] <= '0;
            r_v <= '0;
         end else begin
            r_d[0] <= push ? vec[r*WORD_LEN +: WORD_LEN] : '0;
            r_v[0] <= push;
            for (int i = 1; i <= r; i++) begin
               r_d[i] <= r_d[i-1];
               r_v[i] <= r_v[i-1];
            end
         end
      end

      assign row_dat[r*WORD_LEN +: WORD_LEN] = r_d[r];
      assign row_vld[r]                      = r_v[r];
   end

endmodule
`default_nettype wire

// File: rtl/row_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : row_feeder                                                  |
// | Reads ROWS-word vectors from input memory and feeds them, skewed,     |
// | into the systolic array rows with arr_rdy back-pressure.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module row_feeder
   import arr_pkg::*;
#(
   parameter int ROWS     = c_ROWS,
   parameter int WORD_LEN = c_WORD_LEN,
   parameter int ADDR_W   = c_ADDR_W
) (
   input  wire logic    clk,
   input  wire logic    rst,
   row_feeder_if.master bus
);

   localparam int CW = $clog2(ROWS + 1);
   localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

   feed_state_t                   r_state;
   feed_state_t                   w_state_nxt;
   logic [ADDR_W-1:0]             r_addr;
   logic [7:0]                    r_nvecs;
   logic [7:0]                    r_vcnt;
   logic [CW-1:0]                 r_fcnt;
   logic [CW-1:0]                 r_dcnt;
   logic [ROWS-1:0][WORD_LEN-1:0] r_buf;
   logic                          w_issue;
   logic                          w_push;
   logic                          w_more;
   logic [IW-1:0]                 w_widx;
   logic [ROWS*WORD_LEN-1:0]      w_vec;
   logic [ROWS*WORD_LEN-1:0]      w_row_dat;
   logic [ROWS-1:0]               w_row_vld;

   // Reads go out on FETCH cycles 0..ROWS-1; the last FETCH cycle only captures
   assign w_issue = (r_state == S_FETCH) && (r_fcnt < CW'(ROWS));
   assign w_push  = (r_state == S_EMIT) && bus.arr_rdy;
   assign w_more  = ({1'b0, r_vcnt} + 9'd1) < {1'b0, r_nvecs};
   assign w_widx  = IW'(r_fcnt - CW'(1));
   assign w_vec   = r_buf;

   assign bus.mem_cen = ~w_issue;
   assign bus.mem_wen = 1'b1;
   assign bus.mem_a   = w_issue ? (r_addr + ADDR_W'(r_fcnt)) : '0;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = (r_state == S_DONE);
   assign bus.row_dat = w_row_dat;
   assign bus.row_vld = w_row_vld;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = (bus.num_vecs != 8'd0) ? S_FETCH : S_DONE;
         S_FETCH: if (r_fcnt == CW'(ROWS)) w_state_nxt = S_EMIT;
         S_EMIT:  if (bus.arr_rdy) w_state_nxt = w_more ? S_FETCH : S_DRAIN;
         S_DRAIN: if (r_dcnt == CW'(ROWS - 1)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Run parameters, counters and the vector buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_nvecs <= '0;
         r_vcnt  <= '0;
         r_fcnt  <= '0;
         r_dcnt  <= '0;
         r_buf   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_addr  <= bus.base_addr;
                  r_nvecs <= bus.num_vecs;
                  r_vcnt  <= '0;
                  r_fcnt  <= '0;
                  r_dcnt  <= '0;
               end
            end
            S_FETCH: begin
               r_fcnt <= r_fcnt + CW'(1);
               // Read data for address k lands one cycle after its request
               if (r_fcnt != '0) r_buf[w_widx] <= bus.mem_q;
            end
            S_EMIT: begin
               if (bus.arr_rdy) begin
                  r_vcnt <= r_vcnt + 8'd1;
                  r_addr <= r_addr + ADDR_W'(ROWS);
                  r_fcnt <= '0;
               end
            end
            S_DRAIN: r_dcnt <= r_dcnt + CW'(1);
            default: ;
         endcase
      end
   end

   row_skew #(
      .ROWS     (ROWS),
      .WORD_LEN (WORD_LEN)
   ) u_skew (
      .clk     (clk),
      .rst     (rst),
      .vec     (w_vec),
      .push    (w_push),
      .row_dat (w_row_dat),
      .row_vld (w_row_vld)
   );

endmodule
`default_nettype wire

// File: tb/tb_row_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_row_feeder                                               |
// | Scoreboard bench for row_feeder with ROWS=4.                          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_row_feeder;

   localparam int ROWS = 4;
   localparam int WL   = 8;
   localparam int AW   = 15;
   localparam int BIG  = 32'h7fff_ffff;

   typedef struct {
      int cyc;
      int row;
      int val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   last_done = 0;

   exp_t q_row[$];
   exp_t q_addr[$];
   exp_t q_done[$];

   row_feeder_if #(.ROWS(ROWS), .WORD_LEN(WL), .ADDR_W(AW)) bus ();

   row_feeder #(.ROWS(ROWS), .WORD_LEN(WL), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents: mem[a] = a+1 (low byte)
   function automatic int memdata(input int a);
      return (a + 1) & 255;
   endfunction

   always @(posedge clk) if (!bus.mem_cen) bus.mem_q <= WL'(memdata(int'(bus.mem_a)));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected reads, row outputs and done for a run starting in cycle c;
   // stall delays the first push; items at or after cycle lim are dropped.
   function automatic void push_exp(input int c, input int base, input int nv,
                                    input int stall, input int lim);
      int   f;
      int   p;
      int   a;
      exp_t e;
      p = c;
      for (int v = 0; v < nv; v++) begin
         f = c + 1 + 6 * v + ((v > 0) ? stall : 0);
         p = f + 5 + ((v == 0) ? stall : 0);
         for (int k = 0; k < ROWS; k++) begin
            a = (base + ROWS * v + k) & 32'h7FFF;
            e.cyc = f + k; e.row = 0; e.val = a;
            if (e.cyc < lim) q_addr.push_back(e);
            e.cyc = p + 1 + k; e.row = k; e.val = memdata(a);
            if (e.cyc < lim) q_row.push_back(e);
         end
      end
      e.cyc = (nv == 0) ? c + 1 : p + 5; e.row = 0; e.val = 1;
      if (e.cyc < lim) q_done.push_back(e);
      last_done = e.cyc;
   endfunction

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_run(input int base, input int nv, input int stall);
      int c;
      c = cyc;
      push_exp(c, base, nv, stall, BIG);
      bus.start     = 1'b1;
      bus.base_addr = AW'(base);
      bus.num_vecs  = 8'(nv);
      if (stall > 0) bus.arr_rdy = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      if (stall > 0) begin
         wait_until(c + 6 + stall);
         bus.arr_rdy = 1'b1;
      end
      wait_until(last_done + 3);
   endtask

   // Monitor: compares DUT activity against the expectation queues
   always @(negedge clk) begin : mon
      exp_t e;
      logic ok;
      while (q_addr.size() > 0 && q_addr[0].cyc < cyc) begin
         e = q_addr.pop_front(); n_chk++; n_err++;
         $display("FAIL mem_read_missing: got no read, expected addr %h at cycle %0d", e.val, e.cyc);
      end
      while (q_row.size() > 0 && q_row[0].cyc < cyc) begin
         e = q_row.pop_front(); n_chk++; n_err++;
         $display("FAIL row_missing: got no valid row, expected row %0d data %0d at cycle %0d", e.row, e.val, e.cyc);
      end
      while (q_done.size() > 0 && q_done[0].cyc < cyc) begin
         e = q_done.pop_front(); n_chk++; n_err++;
         $display("FAIL done_missing: got done=0, expected done at cycle %0d", e.cyc);
      end
      if (!bus.mem_cen) begin
         n_chk++;
         if (q_addr.size() == 0 || q_addr[0].cyc != cyc) begin
            n_err++;
            $display("FAIL mem_read_unexpected: got addr %h at cycle %0d, expected no read", bus.mem_a, cyc);
         end else begin
            e = q_addr.pop_front();
            if (int'(bus.mem_a) != e.val || bus.mem_wen !== 1'b1) begin
               n_err++;
               $display("FAIL mem_read: got addr %h wen %b, expected addr %h wen 1 (cycle %0d)",
                        bus.mem_a, bus.mem_wen, e.val, cyc);
            end
         end
      end
      if (bus.row_vld != '0) begin
         n_chk++;
         if (q_row.size() == 0 || q_row[0].cyc != cyc) begin
            n_err++;
            $display("FAIL row_unexpected: got vld %b dat %h at cycle %0d, expected bubble",
                     bus.row_vld, bus.row_dat, cyc);
         end else begin
            e  = q_row.pop_front();
            ok = (bus.row_vld == ROWS'(1 << e.row)) && (int'(bus.row_dat[e.row*WL +: WL]) == e.val);
            if (!ok) begin
               n_err++;
               $display("FAIL row_data: got vld %b dat %h, expected row %0d data %0d (cycle %0d)",
                        bus.row_vld, bus.row_dat, e.row, e.val, cyc);
            end
         end
      end
      ok = 1'b1;
      for (int r = 0; r < ROWS; r++)
         if (!bus.row_vld[r] && bus.row_dat[r*WL +: WL] != '0) ok = 1'b0;
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL bubble_zero: got vld %b dat %h, expected zero data on idle lanes (cycle %0d)",
                  bus.row_vld, bus.row_dat, cyc);
      end
      if (bus.done) begin
         n_chk++;
         if (q_done.size() == 0 || q_done[0].cyc != cyc) begin
            n_err++;
            $display("FAIL done_unexpected: got done=1 at cycle %0d, expected 0", cyc);
         end else begin
            void'(q_done.pop_front());
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_cen"}, int'(bus.mem_cen), 1);
      check({tag, "_mem_wen"}, int'(bus.mem_wen), 1);
      check({tag, "_mem_a"},   int'(bus.mem_a), 0);
      check({tag, "_row_dat"}, int'(bus.row_dat), 0);
      check({tag, "_row_vld"}, int'(bus.row_vld), 0);
      check({tag, "_busy"},    int'(bus.busy), 0);
      check({tag, "_done"},    int'(bus.done), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int c;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.num_vecs  = '0;
      bus.arr_rdy   = 1'b1;

      // Reset state
      @(negedge clk);
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single vector, mem[0..3]=1..4
      c = cyc;
      fork
         do_run(0, 1, 0);
         begin
            wait_until(c + 1);
            check("busy_run", int'(bus.busy), 1);
         end
      join

      // Zero-length run: no reads, done one cycle after start, busy one cycle
      c = cyc;
      fork
         do_run(0, 0, 0);
         begin
            wait_until(c + 1);
            check("busy_zero_run", int'(bus.busy), 1);
            wait_until(c + 2);
            check("idle_after_zero_run", int'(bus.busy), 0);
         end
      join

      // Address wrap 0x7FFE..0x0001
      do_run(32'h7FFE, 1, 0);

      // arr_rdy low 3 cycles in EMIT
      do_run(32'h10, 1, 3);

      // Two vectors, address advances by ROWS
      do_run(32'h20, 2, 0);

      // Reset mid-FETCH of vector 2 of 3
      c = cyc;
      push_exp(c, 32'h40, 3, 0, c + 10);
      bus.start = 1'b1; bus.base_addr = AW'(32'h40); bus.num_vecs = 8'd3;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(c + 9);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrun_reset");
      check("midrun_addr_q", q_addr.size(), 0);
      check("midrun_row_q",  q_row.size(), 0);
      check("midrun_done_q", q_done.size(), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_run(32'h50, 2, 0);

      // start while busy is ignored
      c = cyc;
      push_exp(c, 32'h60, 1, 0, BIG);
      bus.start = 1'b1; bus.base_addr = AW'(32'h60); bus.num_vecs = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(c + 3);
      bus.start = 1'b1; bus.base_addr = AW'(32'h100); bus.num_vecs = 8'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(last_done + 8);

      check("final_addr_q", q_addr.size(), 0);
      check("final_row_q",  q_row.size(), 0);
      check("final_done_q", q_done.size(), 0);
      check("final_idle",   int'(bus.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
